// File: rtl/spi_flash_read_seq_if.sv
// rtl/spi_flash_read_seq_if.sv - request, CPU write and engine register port bundle
// slave: the sequencer; master: the requester/CPU/engine side.
interface spi_flash_read_seq_if;
  logic        Req;
  logic [23:0] ReqAddr;
  logic [8:0]  ReqLen;
  logic        ReqSlow;
  logic        Ready;
  logic        Done;
  logic        CpuWriteTX;
  logic        CpuWriteCntLo;
  logic        CpuWriteCntHi;
  logic [8:0]  CpuAddr;
  logic [7:0]  CpuData;
  logic        CpuConflict;
  logic        EngWriteTX;
  logic        EngWriteCntLo;
  logic        EngWriteCntHi;
  logic [8:0]  EngAddr;
  logic [7:0]  EngData;
  logic        EngBusy;

  modport slave (
    input  Req, ReqAddr, ReqLen, ReqSlow,
    input  CpuWriteTX, CpuWriteCntLo, CpuWriteCntHi, CpuAddr, CpuData,
    input  EngBusy,
    output Ready, Done, CpuConflict,
    output EngWriteTX, EngWriteCntLo, EngWriteCntHi, EngAddr, EngData
  );

  modport master (
    output Req, ReqAddr, ReqLen, ReqSlow,
    output CpuWriteTX, CpuWriteCntLo, CpuWriteCntHi, CpuAddr, CpuData,
    output EngBusy,
    input  Ready, Done, CpuConflict,
    input  EngWriteTX, EngWriteCntLo, EngWriteCntHi, EngAddr, EngData
  );
endinterface

// File: rtl/spi_flash_read_seq.sv
// rtl/spi_flash_read_seq.sv - SPI flash read sequencer owning the engine register write port
// Define SPI_SEQ_FASTREAD_EN for the 0x0B fast-read command with a trailing dummy byte.
module spi_flash_read_seq #(
  parameter bit SLOW_CLK_DEFAULT = 1'b0
) (
  input logic                 FastClk,
  input logic                 Reset,
  spi_flash_read_seq_if.slave bus
);

`ifdef SPI_SEQ_FASTREAD_EN
  localparam int unsigned    N_TX     = 5;
  localparam logic [7:0]     CMD_BYTE = 8'h0B;
`else
  localparam int unsigned    N_TX     = 4;
  localparam logic [7:0]     CMD_BYTE = 8'h03;
`endif
  localparam logic [2:0]     LAST_IDX = 3'(N_TX - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_TX,
    S_CMD_LEN,
    S_CMD_GO,
    S_CMD_GUARD,
    S_CMD_WAIT,
    S_DAT_LEN,
    S_DAT_GO,
    S_DAT_GUARD,
    S_DAT_WAIT,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [23:0] r_addr;
  logic [8:0]  r_len;
  logic        r_slow;
  logic        r_conflict;
  logic        r_tx_we;
  logic        r_lo_we;
  logic        r_hi_we;
  logic [8:0]  r_eng_addr;
  logic [7:0]  r_eng_data;

  state_t      w_nxt_state;
  logic [2:0]  w_nxt_idx;
  logic        w_cpu_any;
  logic        w_accept;
  logic [7:0]  w_tx_byte;
  logic        w_nxt_tx_we;
  logic        w_nxt_lo_we;
  logic        w_nxt_hi_we;
  logic [8:0]  w_nxt_eng_addr;
  logic [7:0]  w_nxt_eng_data;

  assign w_cpu_any = bus.CpuWriteTX | bus.CpuWriteCntLo | bus.CpuWriteCntHi;
  // A CPU strobe owns the port in the cycle it appears; Req simply retries.
  assign w_accept  = (r_state == S_IDLE) & bus.Req & ~bus.EngBusy & ~w_cpu_any;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_nxt_state = S_LOAD_TX;
          w_nxt_idx   = 3'd0;
        end
      end
      S_LOAD_TX: begin
        if (r_idx == LAST_IDX) begin
          w_nxt_state = S_CMD_LEN;
          w_nxt_idx   = 3'd0;
        end else begin
          w_nxt_idx   = r_idx + 3'd1;
        end
      end
      S_CMD_LEN:   w_nxt_state = S_CMD_GO;
      S_CMD_GO:    w_nxt_state = S_CMD_GUARD;
      S_CMD_GUARD: w_nxt_state = S_CMD_WAIT;
      S_CMD_WAIT:  if (!bus.EngBusy) w_nxt_state = S_DAT_LEN;
      S_DAT_LEN:   w_nxt_state = S_DAT_GO;
      S_DAT_GO:    w_nxt_state = S_DAT_GUARD;
      S_DAT_GUARD: w_nxt_state = S_DAT_WAIT;
      S_DAT_WAIT:  if (!bus.EngBusy) w_nxt_state = S_RELEASE;
      S_RELEASE:   w_nxt_state = S_DONE;
      S_DONE:      w_nxt_state = S_IDLE;
      default:     w_nxt_state = S_IDLE;
    endcase
  end

  // Any index past the address bytes is the fast-read dummy byte.
  always_comb begin
    w_tx_byte = 8'h00;
    case (w_nxt_idx)
      3'd0:    w_tx_byte = CMD_BYTE;
      3'd1:    w_tx_byte = r_addr[23:16];
      3'd2:    w_tx_byte = r_addr[15:8];
      3'd3:    w_tx_byte = r_addr[7:0];
      default: w_tx_byte = 8'h00;
    endcase
  end

  // Strobes are decoded from the next state so they leave a register.
  always_comb begin
    w_nxt_tx_we    = 1'b0;
    w_nxt_lo_we    = 1'b0;
    w_nxt_hi_we    = 1'b0;
    w_nxt_eng_addr = 9'd0;
    w_nxt_eng_data = 8'h00;
    case (w_nxt_state)
      S_LOAD_TX: begin
        w_nxt_tx_we    = 1'b1;
        w_nxt_eng_addr = {6'd0, w_nxt_idx};
        w_nxt_eng_data = w_tx_byte;
      end
      S_CMD_LEN: begin
        w_nxt_lo_we    = 1'b1;
        w_nxt_eng_data = 8'(N_TX - 1);
      end
      S_CMD_GO: begin
        w_nxt_hi_we    = 1'b1;
        w_nxt_eng_data = 8'hE0 | {4'd0, r_slow, 3'd0};
      end
      S_DAT_LEN: begin
        w_nxt_lo_we    = 1'b1;
        w_nxt_eng_data = r_len[7:0];
      end
      S_DAT_GO: begin
        w_nxt_hi_we    = 1'b1;
        w_nxt_eng_data = 8'hE2 | {4'd0, r_slow, 2'd0, r_len[8]};
      end
      S_RELEASE: begin
        w_nxt_hi_we    = 1'b1;
        w_nxt_eng_data = 8'h00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge FastClk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_addr     <= 24'd0;
      r_len      <= 9'd0;
      r_slow     <= 1'b0;
      r_conflict <= 1'b0;
      r_tx_we    <= 1'b0;
      r_lo_we    <= 1'b0;
      r_hi_we    <= 1'b0;
      r_eng_addr <= 9'd0;
      r_eng_data <= 8'h00;
    end else begin
      r_state    <= w_nxt_state;
      r_idx      <= w_nxt_idx;
      r_tx_we    <= w_nxt_tx_we;
      r_lo_we    <= w_nxt_lo_we;
      r_hi_we    <= w_nxt_hi_we;
      r_eng_addr <= w_nxt_eng_addr;
      r_eng_data <= w_nxt_eng_data;
      if (w_accept) begin
        r_addr     <= bus.ReqAddr;
        r_len      <= bus.ReqLen;
        r_slow     <= bus.ReqSlow | SLOW_CLK_DEFAULT;
        r_conflict <= 1'b0;
      end else if ((r_state != S_IDLE) && w_cpu_any) begin
        r_conflict <= 1'b1;
      end
    end
  end

  always_comb begin
    if (r_state == S_IDLE) begin
      bus.EngWriteTX    = bus.CpuWriteTX;
      bus.EngWriteCntLo = bus.CpuWriteCntLo;
      bus.EngWriteCntHi = bus.CpuWriteCntHi;
      bus.EngAddr       = w_cpu_any ? bus.CpuAddr : 9'd0;
      bus.EngData       = w_cpu_any ? bus.CpuData : 8'h00;
    end else begin
      bus.EngWriteTX    = r_tx_we;
      bus.EngWriteCntLo = r_lo_we;
      bus.EngWriteCntHi = r_hi_we;
      bus.EngAddr       = r_eng_addr;
      bus.EngData       = r_eng_data;
    end
  end

  assign bus.Ready       = (r_state == S_IDLE);
  assign bus.Done        = (r_state == S_DONE);
  assign bus.CpuConflict = r_conflict;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// tb/tb_spi_flash_read_seq.sv - directed bench for spi_flash_read_seq
// Small engine model raises EngBusy one cycle after a start write; all engine writes are logged.
module tb_spi_flash_read_seq;

`ifdef SPI_SEQ_FASTREAD_EN
  localparam int         NTX = 5;
  localparam logic [7:0] CMD = 8'h0B;
`else
  localparam int         NTX = 4;
  localparam logic [7:0] CMD = 8'h03;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_flash_read_seq_if bus ();

  spi_flash_read_seq #(.SLOW_CLK_DEFAULT(1'b0)) dut (
    .FastClk(clk),
    .Reset  (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic [1:0] k, input logic [8:0] a, input logic [7:0] d);
    return {13'd0, k, a, d};
  endfunction

  int busy_len = 3;
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (bus.EngWriteCntHi && bus.EngData[7]) busy_cnt <= busy_len;
    else if (busy_cnt != 0)                  busy_cnt <= busy_cnt - 1;
  end
  assign bus.EngBusy = (busy_cnt != 0);

  logic [31:0] log_q[$];
  logic [31:0] exp_q[$];
  int done_cnt  = 0;
  int multi_cnt = 0;
  always @(negedge clk) begin
    if (bus.EngWriteTX)    log_q.push_back(ent(2'd1, bus.EngAddr, bus.EngData));
    if (bus.EngWriteCntLo) log_q.push_back(ent(2'd2, bus.EngAddr, bus.EngData));
    if (bus.EngWriteCntHi) log_q.push_back(ent(2'd3, bus.EngAddr, bus.EngData));
    if (int'(bus.EngWriteTX) + int'(bus.EngWriteCntLo) + int'(bus.EngWriteCntHi) > 1)
      multi_cnt <= multi_cnt + 1;
    if (bus.Done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [31:0] log_at(input int i);
    return (i < log_q.size()) ? log_q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic build_exp(input logic [23:0] a, input logic [8:0] len, input logic slow);
    exp_q.delete();
    exp_q.push_back(ent(2'd1, 9'd0, CMD));
    exp_q.push_back(ent(2'd1, 9'd1, a[23:16]));
    exp_q.push_back(ent(2'd1, 9'd2, a[15:8]));
    exp_q.push_back(ent(2'd1, 9'd3, a[7:0]));
    if (NTX == 5) exp_q.push_back(ent(2'd1, 9'd4, 8'h00));
    exp_q.push_back(ent(2'd2, 9'd0, 8'(NTX - 1)));
    exp_q.push_back(ent(2'd3, 9'd0, slow ? 8'hE8 : 8'hE0));
    exp_q.push_back(ent(2'd2, 9'd0, len[7:0]));
    exp_q.push_back(ent(2'd3, 9'd0, (slow ? 8'hEA : 8'hE2) | {7'd0, len[8]}));
    exp_q.push_back(ent(2'd3, 9'd0, 8'h00));
  endtask

  task automatic compare_log(input string tag, input int offset);
    check({tag, "_log_len"}, log_q.size(), exp_q.size() + offset);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_log%0d", tag, i), log_at(i + offset), exp_q[i]);
  endtask

  task automatic run_read(input string tag, input logic [23:0] a, input logic [8:0] len,
                          input logic slow, input int busy, input int inject_k);
    int k;
    int done_k;
    int base;
    bit seen;
    busy_len = busy;
    build_exp(a, len, slow);
    @(posedge clk); #1;
    log_q.delete();
    base        = done_cnt;
    bus.Req     = 1'b1;
    bus.ReqAddr = a;
    bus.ReqLen  = len;
    bus.ReqSlow = slow;
    k = 0; done_k = 0; seen = 1'b0;
    while (!seen && k < 300) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) bus.Req = 1'b0;
      bus.CpuWriteTX = (k == inject_k);
      bus.CpuAddr    = (k == inject_k) ? 9'h077 : 9'h000;
      bus.CpuData    = (k == inject_k) ? 8'hAA : 8'h00;
      @(negedge clk);
      if (k == 1) begin
        check({tag, "_ready_fall"}, bus.Ready, 1'b0);
        check({tag, "_first_tx"}, bus.EngWriteTX, 1'b1);
        check({tag, "_conflict_clr"}, bus.CpuConflict, 1'b0);
      end
      if (bus.Done) begin
        seen   = 1'b1;
        done_k = k;
        check({tag, "_busy_at_done"}, bus.EngBusy, 1'b0);
      end
    end
    check({tag, "_done_seen"}, seen, 1'b1);
    check({tag, "_done_cycle"}, done_k, NTX + 8 + 2 * busy);
    @(posedge clk); #1;
    bus.CpuWriteTX = 1'b0;
    @(negedge clk);
    check({tag, "_ready_rise"}, bus.Ready, 1'b1);
    check({tag, "_done_pulse"}, bus.Done, 1'b0);
    check({tag, "_done_cnt"}, done_cnt - base, 1);
    check({tag, "_multi"}, multi_cnt, 0);
    compare_log(tag, 0);
  endtask

  initial begin
    int base;
    bit seen;
    rst = 1'b1;
    bus.Req = 1'b0; bus.ReqAddr = '0; bus.ReqLen = '0; bus.ReqSlow = 1'b0;
    bus.CpuWriteTX = 1'b0; bus.CpuWriteCntLo = 1'b0; bus.CpuWriteCntHi = 1'b0;
    bus.CpuAddr = '0; bus.CpuData = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.Ready, 1'b1);
    check("rst_done", bus.Done, 1'b0);
    check("rst_conflict", bus.CpuConflict, 1'b0);
    check("rst_strobes", {bus.EngWriteTX, bus.EngWriteCntLo, bus.EngWriteCntHi}, 3'b000);
    check("rst_addr", bus.EngAddr, 9'd0);
    check("rst_data", bus.EngData, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    run_read("basic", 24'h123456, 9'd3, 1'b0, 3, 0);
    check("basic_tx1", log_at(1), ent(2'd1, 9'd1, 8'h12));
    check("basic_cmdgo", log_at(NTX + 1), ent(2'd3, 9'd0, 8'hE0));

    run_read("slow", 24'hABCDEF, 9'h1FF, 1'b1, 5, 0);
    check("slow_cmdgo", log_at(NTX + 1), ent(2'd3, 9'd0, 8'hE8));
    check("slow_datlen", log_at(NTX + 2), ent(2'd2, 9'd0, 8'hFF));
    check("slow_datgo", log_at(NTX + 3), ent(2'd3, 9'd0, 8'hEB));

    run_read("conflict", 24'h000010, 9'd7, 1'b0, 3, NTX + 4);
    check("conflict_set", bus.CpuConflict, 1'b1);
    run_read("after_conflict", 24'h00ABCD, 9'd0, 1'b0, 2, 0);

`ifdef SPI_SEQ_FASTREAD_EN
    run_read("fast", 24'h000100, 9'd15, 1'b0, 2, 0);
    check("fast_dummy", log_at(4), ent(2'd1, 9'd4, 8'h00));
    check("fast_cmdlen", log_at(5), ent(2'd2, 9'd0, 8'h04));
`else
    run_read("addr100", 24'h000100, 9'd15, 1'b0, 2, 0);
    check("addr100_cmdlen", log_at(4), ent(2'd2, 9'd0, 8'h03));
`endif

    // Req and a CPU hi write in the same idle cycle.
    busy_len = 2;
    build_exp(24'h0F0F0F, 9'd5, 1'b0);
    @(posedge clk); #1;
    log_q.delete();
    base = done_cnt;
    bus.Req = 1'b1; bus.ReqAddr = 24'h0F0F0F; bus.ReqLen = 9'd5; bus.ReqSlow = 1'b0;
    bus.CpuWriteCntHi = 1'b1; bus.CpuAddr = 9'h1A5; bus.CpuData = 8'h5A;
    @(negedge clk);
    check("coll_pass_hi", bus.EngWriteCntHi, 1'b1);
    check("coll_pass_addr", bus.EngAddr, 9'h1A5);
    check("coll_pass_data", bus.EngData, 8'h5A);
    check("coll_pass_tx", bus.EngWriteTX, 1'b0);
    @(posedge clk); #1;
    bus.CpuWriteCntHi = 1'b0; bus.CpuAddr = '0; bus.CpuData = '0;
    @(negedge clk);
    check("coll_not_acc", bus.Ready, 1'b1);
    check("coll_idle_addr", bus.EngAddr, 9'd0);
    @(posedge clk); #1;
    bus.Req = 1'b0;
    @(negedge clk);
    check("coll_acc_ready", bus.Ready, 1'b0);
    check("coll_acc_tx", bus.EngWriteTX, 1'b1);
    check("coll_acc_data", bus.EngData, CMD);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.Done) seen = 1'b1;
    end
    check("coll_done_seen", seen, 1'b1);
    @(negedge clk);
    check("coll_done_cnt", done_cnt - base, 1);
    check("coll_cpu_entry", log_at(0), ent(2'd3, 9'h1A5, 8'h5A));
    compare_log("coll", 1);

    // Reset in the second DAT_WAIT cycle.
    busy_len = 6;
    @(posedge clk); #1;
    log_q.delete();
    base = done_cnt;
    bus.Req = 1'b1; bus.ReqAddr = 24'h55AA33; bus.ReqLen = 9'd2; bus.ReqSlow = 1'b0;
    for (int k = 1; k <= NTX + 14; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.Req = 1'b0;
      if (k == NTX + 14) rst = 1'b1;
      @(negedge clk);
    end
    check("rstmid_pre_ready", bus.Ready, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready", bus.Ready, 1'b1);
    check("rstmid_done", bus.Done, 1'b0);
    repeat (10) @(negedge clk);
    check("rstmid_log_len", log_q.size(), NTX + 4);
    check("rstmid_no_done", done_cnt - base, 0);
    check("rstmid_strobes", {bus.EngWriteTX, bus.EngWriteCntLo, bus.EngWriteCntHi}, 3'b000);
    check("rstmid_conflict", bus.CpuConflict, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
